// File: rtl/merge_engine_pkg.sv
// merge_engine_pkg
// Shared definitions for the 2048 merge engine: tile and board geometry,
// move direction encodings, the controller state type and the helper that
// maps (direction, line, position-along-line) onto a board tile index.
//
// Tile i of the board lives at bits [4i+3:4i] with i = 4*row + col,
// row 0 at the top and col 0 at the left.

package merge_engine_pkg;

    localparam int TILE_W   = 4;
    localparam int N_TILES  = 16;
    localparam int LINE_LEN = 4;
    localparam int BOARD_W  = TILE_W * N_TILES;

    // The largest exponent never merges, so a tile can never overflow.
    localparam logic [TILE_W-1:0] MAX_EXP = '1;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [1:0] LAST_LINE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROC,
        ST_DONE
    } state_t;

    // Board index of element 'pos' of line 'line' for a move in 'dir'.
    // Element 0 is always the leading edge the tiles slide toward. Because
    // the index is 4*row + col, {row, col} is the index itself.
    function automatic logic [3:0] tile_index(input logic [1:0] dir,
                                              input logic [1:0] line,
                                              input logic [1:0] pos);
        logic [1:0] rpos;
        rpos = 2'd3 - pos;
        case (dir)
            DIR_LEFT:  return {line, pos};
            DIR_RIGHT: return {line, rpos};
            DIR_UP:    return {pos, line};
            default:   return {rpos, line};
        endcase
    endfunction

endpackage

// File: rtl/merge_engine_line_merge.sv
// line_merge
// Purely combinational 2048 rule for one line of four tiles.
// Element 0 is the leading edge. Non-zero tiles are first packed toward
// element 0, then equal neighbours are merged scanning from element 0,
// each tile merging at most once and exponent 15 never merging.
//
// Ports:
//   line_in     : four input exponents, element j at [4j+3:4j]
//   line_out    : four result exponents, same packing
//   merge_flags : bit j set when result element j came from a merge

module line_merge
    import merge_engine_pkg::*;
(
    input  logic [LINE_LEN*TILE_W-1:0] line_in,
    output logic [LINE_LEN*TILE_W-1:0] line_out,
    output logic [LINE_LEN-1:0]        merge_flags
);

    logic [TILE_W-1:0]   comp [LINE_LEN];
    logic [TILE_W-1:0]   res  [LINE_LEN];
    logic [LINE_LEN-1:0] pair_merge;

    // Slide every non-zero tile toward element 0, keeping their order;
    // the vacated tail positions are left as empty tiles.
    always_comb begin : compress
        logic [2:0] fill;
        for (int j = 0; j < LINE_LEN; j++) begin
            comp[j] = '0;
        end
        fill = '0;
        for (int j = 0; j < LINE_LEN; j++) begin
            if (line_in[j*TILE_W +: TILE_W] != '0) begin
                comp[fill[1:0]] = line_in[j*TILE_W +: TILE_W];
                fill = fill + 3'd1;
            end
        end
    end

    // Mark which packed neighbours could merge if neither has already been
    // consumed; the last element has no right-hand neighbour.
    always_comb begin
        pair_merge = '0;
        for (int j = 0; j < LINE_LEN - 1; j++) begin
            pair_merge[j] = (comp[j] != '0) && (comp[j] == comp[j+1]) &&
                            (comp[j] != MAX_EXP);
        end
    end

    // Walk the packed line from the leading edge. A merge consumes the
    // partner too, so the next element is skipped, which is what keeps a
    // run like 1,1,1,1 from collapsing into a single tile.
    always_comb begin : scan
        logic [2:0] out_pos;
        logic       skip;
        for (int j = 0; j < LINE_LEN; j++) begin
            res[j] = '0;
        end
        merge_flags = '0;
        out_pos     = '0;
        skip        = 1'b0;
        for (int j = 0; j < LINE_LEN; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[j] != '0) begin
                if (pair_merge[j]) begin
                    res[out_pos[1:0]]         = comp[j] + TILE_W'(1);
                    merge_flags[out_pos[1:0]] = 1'b1;
                    skip                      = 1'b1;
                end else begin
                    res[out_pos[1:0]] = comp[j];
                end
                out_pos = out_pos + 3'd1;
            end
        end
    end

    // Flatten the result array back onto the packed output bus.
    always_comb begin
        line_out = '0;
        for (int j = 0; j < LINE_LEN; j++) begin
            line_out[j*TILE_W +: TILE_W] = res[j];
        end
    end

endmodule

// File: rtl/merge_engine.sv
// merge_engine
// Owns the 4x4 2048 board and executes one move per command, one line per
// cycle through a single shared line_merge. The finished board and the
// one-cycle per-tile merge flags form the producer side of the board/score
// interface feeding the score accumulator. Also writes spawned tiles and
// reports when no legal move remains.
//
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   move_valid    : move request, taken only while move_ready is high
//   move_dir      : 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN
//   move_ready    : high only while idle
//   spawn_valid   : request to write spawn_exp into tile spawn_idx
//   spawn_idx     : target tile index
//   spawn_exp     : exponent to write (0 is rejected)
//   spawn_ok      : one-cycle pulse after a spawn was written
//   board         : tile i at bits [4i+3:4i], i = 4*row + col
//   score_signal  : bit i set when tile i of the new board is a merge result
//   done          : one-cycle pulse when a move completes
//   moved         : last move changed the board, held until the next done
//   game_over     : no empty tile and no mergeable neighbour pair

module merge_engine
    import merge_engine_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               move_valid,
    input  logic [1:0]         move_dir,
    output logic               move_ready,
    input  logic               spawn_valid,
    input  logic [3:0]         spawn_idx,
    input  logic [TILE_W-1:0]  spawn_exp,
    output logic               spawn_ok,
    output logic [BOARD_W-1:0] board,
    output logic [N_TILES-1:0] score_signal,
    output logic               done,
    output logic               moved,
    output logic               game_over
);

    state_t                     state;
    logic [1:0]                 dir_q;
    logic [1:0]                 line_cnt;
    logic [BOARD_W-1:0]         shadow;
    logic [BOARD_W-1:0]         next_shadow;
    logic [N_TILES-1:0]         flags;
    logic [N_TILES-1:0]         next_flags;
    logic [3:0]                 line_idx [LINE_LEN];
    logic [LINE_LEN*TILE_W-1:0] line_in;
    logic [LINE_LEN*TILE_W-1:0] line_out;
    logic [LINE_LEN-1:0]        line_flags;
    logic                       spawn_accept;
    logic                       can_move;

    // Board positions of the four elements of the line being processed.
    always_comb begin
        for (int j = 0; j < LINE_LEN; j++) begin
            line_idx[j] = tile_index(dir_q, line_cnt, 2'(j));
        end
    end

    // Gather the current line out of the shadow copy, leading edge first.
    always_comb begin
        line_in = '0;
        for (int j = 0; j < LINE_LEN; j++) begin
            line_in[j*TILE_W +: TILE_W] = shadow[int'(line_idx[j])*TILE_W +: TILE_W];
        end
    end

    line_merge u_line_merge (
        .line_in     (line_in),
        .line_out    (line_out),
        .merge_flags (line_flags)
    );

    // Scatter the merged line back through the same mapping so the shadow
    // and the flag vector both stay in board order.
    always_comb begin
        next_shadow = shadow;
        next_flags  = flags;
        for (int j = 0; j < LINE_LEN; j++) begin
            next_shadow[int'(line_idx[j])*TILE_W +: TILE_W] = line_out[j*TILE_W +: TILE_W];
            next_flags[line_idx[j]] = line_flags[j];
        end
    end

    // A spawn only lands on an empty tile with a real exponent, and only
    // while idle with no competing move, since a move always wins.
    always_comb begin
        spawn_accept = (state == ST_IDLE) && spawn_valid && !move_valid &&
                       (spawn_exp != '0) &&
                       (board[int'(spawn_idx)*TILE_W +: TILE_W] == '0);
    end

    // A move is still possible while any tile is empty or any horizontal or
    // vertical neighbour pair is equal and below the non-merging exponent.
    always_comb begin
        logic [TILE_W-1:0] a;
        logic [TILE_W-1:0] b;
        can_move = 1'b0;
        for (int i = 0; i < N_TILES; i++) begin
            if (board[i*TILE_W +: TILE_W] == '0) begin
                can_move = 1'b1;
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                a = board[(4*r + c)*TILE_W +: TILE_W];
                b = board[(4*r + c + 1)*TILE_W +: TILE_W];
                if ((a == b) && (a != MAX_EXP)) begin
                    can_move = 1'b1;
                end
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                a = board[(4*r + c)*TILE_W +: TILE_W];
                b = board[(4*r + c + 4)*TILE_W +: TILE_W];
                if ((a == b) && (a != MAX_EXP)) begin
                    can_move = 1'b1;
                end
            end
        end
    end

    // Controller. A move works on a private shadow copy so that the visible
    // board only ever changes in one edge at the end; a reset mid-move
    // therefore never exposes a half-processed board. The merge flags are
    // published together with that board and cleared one cycle later so the
    // accumulator sees each merge exactly once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            move_ready   <= 1'b1;
            dir_q        <= DIR_LEFT;
            line_cnt     <= '0;
            shadow       <= '0;
            flags        <= '0;
            board        <= '0;
            score_signal <= '0;
            done         <= 1'b0;
            moved        <= 1'b0;
            spawn_ok     <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            game_over <= !can_move;
            spawn_ok  <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (move_valid) begin
                        dir_q      <= move_dir;
                        shadow     <= board;
                        flags      <= '0;
                        line_cnt   <= '0;
                        move_ready <= 1'b0;
                        state      <= ST_PROC;
                    end else if (spawn_accept) begin
                        board[int'(spawn_idx)*TILE_W +: TILE_W] <= spawn_exp;
                        spawn_ok <= 1'b1;
                    end
                end
                ST_PROC: begin
                    if (line_cnt == LAST_LINE) begin
                        board        <= next_shadow;
                        score_signal <= next_flags;
                        moved        <= (next_shadow != board);
                        done         <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        shadow   <= next_shadow;
                        flags    <= next_flags;
                        line_cnt <= line_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    score_signal <= '0;
                    move_ready   <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    move_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_merge_engine.sv
// tb_merge_engine
// Scoreboard bench for merge_engine. Moves and spawns push their expected
// outcome, computed by a grid-and-queue model of the 2048 rules, into
// queues; a monitor pops them whenever done or spawn_ok is presented.

module tb_merge_engine;

    logic        clk;
    logic        rst;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        spawn_valid;
    logic [3:0]  spawn_idx;
    logic [3:0]  spawn_exp;
    logic        spawn_ok;
    logic [63:0] board;
    logic [15:0] score_signal;
    logic        done;
    logic        moved;
    logic        game_over;

    typedef struct {
        logic [63:0] b;
        logic [15:0] s;
        logic        m;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] spawn_q[$];
    logic [63:0] mdl_board;
    int          total;
    int          bad;

    merge_engine dut (
        .clk          (clk),
        .rst          (rst),
        .move_valid   (move_valid),
        .move_dir     (move_dir),
        .move_ready   (move_ready),
        .spawn_valid  (spawn_valid),
        .spawn_idx    (spawn_idx),
        .spawn_exp    (spawn_exp),
        .spawn_ok     (spawn_ok),
        .board        (board),
        .score_signal (score_signal),
        .done         (done),
        .moved        (moved),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies the 2048 rules to a 4x4 grid: each line is read leading edge
    // first, its tiles are queued, pairs are popped and merged, and the
    // result is written back along the same line.
    function automatic logic [63:0] ref_move(input logic [63:0] b, input int dir,
                                             output logic [15:0] fl);
        int g[4][4];
        int rows[4];
        int cols[4];
        int q[$];
        int res[$];
        int mf[$];
        int a;
        int v;
        int idx;
        logic [63:0] nb;
        fl = '0;
        nb = '0;
        for (int i = 0; i < 16; i++) g[i/4][i%4] = int'(b[i*4 +: 4]);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                case (dir)
                    0:       begin rows[j] = k;     cols[j] = j;     end
                    1:       begin rows[j] = k;     cols[j] = 3 - j; end
                    2:       begin rows[j] = j;     cols[j] = k;     end
                    default: begin rows[j] = 3 - j; cols[j] = k;     end
                endcase
            end
            q.delete();
            res.delete();
            mf.delete();
            for (int j = 0; j < 4; j++)
                if (g[rows[j]][cols[j]] != 0) q.push_back(g[rows[j]][cols[j]]);
            while (q.size() > 0) begin
                a = q.pop_front();
                if (q.size() > 0 && q[0] == a && a < 15) begin
                    void'(q.pop_front());
                    res.push_back(a + 1);
                    mf.push_back(1);
                end else begin
                    res.push_back(a);
                    mf.push_back(0);
                end
            end
            for (int j = 0; j < 4; j++) begin
                idx = rows[j] * 4 + cols[j];
                v = (j < res.size()) ? res[j] : 0;
                nb[idx*4 +: 4] = 4'(v);
                fl[idx] = (j < mf.size()) ? (mf[j] != 0) : 1'b0;
            end
        end
        return nb;
    endfunction

    function automatic logic ref_game_over(input logic [63:0] b);
        int g[4][4];
        for (int i = 0; i < 16; i++) g[i/4][i%4] = int'(b[i*4 +: 4]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (g[r][c] == 0) return 1'b0;
                if (c < 3 && g[r][c] == g[r][c+1] && g[r][c] < 15) return 1'b0;
                if (r < 3 && g[r][c] == g[r+1][c] && g[r][c] < 15) return 1'b0;
            end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        move_valid  = 1'b0;
        spawn_valid = 1'b0;
        repeat (2) step();
        rst       = 1'b1;
        mdl_board = '0;
    endtask

    // Spawn request; the model decides acceptance and predicts the board.
    task automatic do_spawn(input logic [3:0] idx, input logic [3:0] ex);
        logic accept;
        logic [63:0] nb;
        accept = (mdl_board[int'(idx)*4 +: 4] == 4'd0) && (ex != 4'd0);
        spawn_valid = 1'b1;
        spawn_idx   = idx;
        spawn_exp   = ex;
        if (accept) begin
            nb = mdl_board;
            nb[int'(idx)*4 +: 4] = ex;
            spawn_q.push_back(nb);
            mdl_board = nb;
        end
        step();
        spawn_valid = 1'b0;
        checkOutput("spawn_ok", 64'(spawn_ok), 64'(accept));
    endtask

    task automatic load_board(input logic [63:0] b);
        do_reset();
        for (int i = 0; i < 16; i++)
            if (b[i*4 +: 4] != 4'd0) do_spawn(4'(i), b[i*4 +: 4]);
        repeat (2) step();
    endtask

    // Issue one move (optionally with a competing spawn), queue the model's
    // outcome, then check latency, busy handshake and game_over afterwards.
    task automatic applyStimulus(input int dir, input bit with_spawn,
                                 input logic [3:0] sp_idx, input logic [3:0] sp_exp);
        exp_t        e;
        logic [15:0] fl;
        int          lat;
        int          guard;
        bit          ready_high;
        guard = 0;
        while (!move_ready && guard < 20) begin
            step();
            guard++;
        end
        checkOutput("move_ready_idle", 64'(move_ready), 64'(1'b1));
        move_valid  = 1'b1;
        move_dir    = 2'(dir);
        spawn_valid = with_spawn;
        spawn_idx   = sp_idx;
        spawn_exp   = sp_exp;
        e.b = ref_move(mdl_board, dir, fl);
        e.s = fl;
        e.m = (e.b != mdl_board);
        exp_q.push_back(e);
        mdl_board = e.b;
        step();
        move_valid  = 1'b0;
        spawn_valid = 1'b0;
        lat = 1;
        ready_high = 1'b0;
        while (!done && lat < 20) begin
            if (move_ready) ready_high = 1'b1;
            step();
            lat++;
        end
        if (move_ready) ready_high = 1'b1;
        checkOutput("done_latency", 64'(lat), 64'(5));
        checkOutput("ready_low_busy", 64'(ready_high), 64'(1'b0));
        step();
        checkOutput("move_ready_back", 64'(move_ready), 64'(1'b1));
        checkOutput("game_over", 64'(game_over), 64'(ref_game_over(mdl_board)));
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result.
    initial begin : monitor
        exp_t        e;
        logic [63:0] sb;
        bit          prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prev_done) checkOutput("score_cleared", 64'(score_signal), 64'(0));
                if (done) begin
                    checkOutput("done_expected", 64'(exp_q.size() > 0), 64'(1'b1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checkOutput("move_board", board, e.b);
                        checkOutput("score_signal", 64'(score_signal), 64'(e.s));
                        checkOutput("moved", 64'(moved), 64'(e.m));
                    end
                end
                if (spawn_ok) begin
                    checkOutput("spawn_expected", 64'(spawn_q.size() > 0), 64'(1'b1));
                    if (spawn_q.size() > 0) begin
                        sb = spawn_q.pop_front();
                        checkOutput("spawn_board", board, sb);
                    end
                end
            end
            prev_done = done && rst;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [63:0] cb;
        bit          done_seen;
        int          sel;
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        move_valid  = 1'b0;
        move_dir    = 2'd0;
        spawn_valid = 1'b0;
        spawn_idx   = 4'd0;
        spawn_exp   = 4'd0;
        mdl_board   = '0;

        do_reset();
        checkOutput("reset_board", board, 64'h0);
        checkOutput("reset_score", 64'(score_signal), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(1'b0));
        checkOutput("reset_moved", 64'(moved), 64'(1'b0));
        checkOutput("reset_spawn_ok", 64'(spawn_ok), 64'(1'b0));
        checkOutput("reset_game_over", 64'(game_over), 64'(1'b0));
        checkOutput("reset_move_ready", 64'(move_ready), 64'(1'b1));

        load_board(64'h1111);
        applyStimulus(0, 1'b0, 4'd0, 4'd0);
        checkOutput("left_pairs_board", board, 64'h0022);

        load_board(64'h2202);
        applyStimulus(1, 1'b0, 4'd0, 4'd0);
        checkOutput("right_board", board, 64'h3200);

        load_board(64'h0001);
        applyStimulus(0, 1'b0, 4'd0, 4'd0);
        checkOutput("nomove_board", board, 64'h0001);

        load_board(64'h000F000F);
        applyStimulus(2, 1'b0, 4'd0, 4'd0);
        checkOutput("max_exp_board", board, 64'h000F000F);

        load_board(64'h0001);
        do_spawn(4'd5, 4'd2);
        do_spawn(4'd0, 4'd3);
        do_spawn(4'd6, 4'd0);
        step();
        checkOutput("spawn_result", board, 64'h0020_0001);
        applyStimulus(0, 1'b1, 4'd7, 4'd1);
        checkOutput("spawn_dropped", board, 64'h0002_0001);

        load_board(64'h1111);
        move_valid = 1'b1;
        move_dir   = 2'd0;
        step();
        move_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        mdl_board = '0;
        checkOutput("abort_board", board, 64'h0);
        checkOutput("abort_ready", 64'(move_ready), 64'(1'b1));
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_seen = 1'b1;
            step();
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'(1'b0));

        cb = '0;
        for (int i = 0; i < 16; i++) cb[i*4 +: 4] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
        load_board(cb);
        checkOutput("checker_game_over", 64'(game_over), 64'(ref_game_over(mdl_board)));
        cb[3:0] = 4'd2;
        load_board(cb);
        checkOutput("pair_game_over", 64'(game_over), 64'(ref_game_over(mdl_board)));

        do_reset();
        for (int it = 0; it < 120; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5)
                do_spawn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
            else if (sel < 9)
                applyStimulus(int'($urandom_range(0, 3)), 1'b0, 4'd0, 4'd0);
            else
                applyStimulus(int'($urandom_range(0, 3)), 1'b1,
                              4'($urandom_range(0, 15)), 4'($urandom_range(1, 3)));
        end

        repeat (3) step();
        checkOutput("move_queue_drained", 64'(exp_q.size()), 64'(0));
        checkOutput("spawn_queue_drained", 64'(spawn_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/merge_engine.md
Name: merge_engine

Overview:
- Owns the 4x4 board register and executes one 2048 move per command.
- Compresses and merges tiles, then publishes the new board together with one-cycle per-tile merge flags.
- These two outputs are the producer end of the board/score interface that feeds the score accumulator.
- Also accepts new-tile spawns and reports game-over.

Parameters:
- TILE_W, 4, bits per tile exponent (0 = empty, k = tile value 2^k)
- N_TILES, 16, tiles per board (fixed 4x4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- move_valid  in  1  move request
- move_dir  in  2  0=LEFT 1=RIGHT 2=UP 3=DOWN
- move_ready  out  1  high only in IDLE
- spawn_valid  in  1  spawn request
- spawn_idx  in  4  target tile index
- spawn_exp  in  4  exponent to write
- spawn_ok  out  1  one-cycle pulse, spawn written
- board  out  64  tile i at bits [4i+3:4i]; i = 4*row + col; row 0 top, col 0 left
- score_signal  out  16  bit i = tile i of the new board is a merge result
- done  out  1  one-cycle pulse, move complete
- moved  out  1  board changed by the last move; held until the next done
- game_over  out  1  no legal move exists

Behaviour:
- Reset values:
  - board, score_signal, done, moved, spawn_ok and game_over all reset to 0.
  - The FSM resets to IDLE, so move_ready resets to 1.
  - Reset in any state aborts the operation in progress; no partial board is committed.
- FSM states: IDLE -> PROC -> DONE -> IDLE.
- IDLE:
  - move_valid && move_ready at cycle T: capture move_dir and copy board to a shadow register.
  - Line counter is set to 0 and the FSM goes to PROC.
- PROC: cycles T+1..T+4, one line per cycle, line k = 0..3.
  - Line elements e0..e3, where e0 is the leading edge:
    - LEFT: tile(k,j)
    - RIGHT: tile(k,3-j)
    - UP: tile(j,k)
    - DOWN: tile(3-j,k)
  - Processing of each line:
    - Compress non-zero elements toward e0.
    - Scan from e0: equal adjacent pair -> one element of exp+1.
    - Each tile participates in at most one merge.
    - Exponent 15 never merges (no overflow).
  - Each result is written back into the shadow register through the same mapping.
  - The merged positions set the corresponding flag bits.
- End of T+4 (one clock edge):
  - board <= shadow
  - score_signal <= flags
  - moved <= (shadow != old board)
  - FSM goes to DONE
- DONE (cycle T+5):
  - done = 1.
  - score_signal is valid in the same cycle as the new board.
  - Next edge: score_signal <= 0, FSM goes to IDLE.
- Fixed latency is 5 cycles from accept to done.
- score_signal is non-zero for exactly one cycle per move, so the downstream accumulator never double-counts.
- A move that changes nothing still pulses done, with moved = 0 and score_signal = 0.
- move_valid outside IDLE is ignored.
- Spawn (IDLE only):
  - Accepted when the target tile is 0 and spawn_exp != 0.
  - The tile is written at the next edge and spawn_ok pulses in the following cycle.
  - An occupied target, spawn_exp = 0, or a non-IDLE state -> ignored, spawn_ok stays 0.
  - Simultaneous move_valid and spawn_valid in IDLE: the move wins and the spawn is dropped.
- game_over:
  - Registered; recomputed every cycle from board.
  - 1 when there is no zero tile and no horizontally or vertically adjacent equal pair with exponent < 15.

Decomposition:
- Shared package:
  - TILE_W and N_TILES.
  - Direction encodings DIR_LEFT/RIGHT/UP/DOWN.
  - FSM state encoding.
  - Tile index helper constants.
- Sub-module line_merge:
  - Purely combinational.
  - Inputs: 4 exponents.
  - Outputs: 4 result exponents and a 4-bit merge-flag vector.
  - Instantiated once and reused per PROC cycle.

Test Plan:
- board=64'h1111, LEFT -> at T+5 board=64'h0022, score_signal=16'h0003, done=1, moved=1; the next cycle has score_signal=0.
- board=64'h2202, RIGHT -> board=64'h3200, score_signal=16'h0008, moved=1.
- board=64'h0001, LEFT -> done at exactly T+5, moved=0, score_signal=0, board unchanged; move_ready is low during T+1..T+5.
- tile0=F, tile4=F (board=64'h000F000F), UP -> no merge, board unchanged, moved=0.
- Spawn into an empty tile -> spawn_ok pulses and the tile is written. Spawn into an occupied tile -> ignored. Spawn with spawn_exp=0 -> ignored. Spawn together with move_valid -> move executes, spawn dropped.
- rst low during PROC -> next cycle board=0, move_ready=1, no done. Full checkerboard of exponents 1/2 -> game_over=1; changing one tile to create an equal adjacent pair -> game_over=0.
